axi4_lite_slave: RTL and testbench

AXI4-Lite slave exposing a small bank of 32-bit read/write registers to an AXI4-Lite master (Vivado AXI VIP in simulation, CPU interconnect in silicon). Write (AW/W/B) and read (AR/R) channels run independently, with no burst or strobe support. Every access is a single full 32-bit word.

---
 rtl/axi4_lite_slave.sv | 196 +++++++++++++++++++
 tb/tb_axi4_lite_slave.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_slave.sv
// rtl/axi4_lite_slave.sv - AXI4-Lite slave with a small bank of 32-bit registers
module axi4_lite_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 4
) (
  input  logic                  A_CLK,
  input  logic                  A_RSTn,
  input  logic                  AW_VALID,
  output logic                  AW_READY,
  input  logic [ADDR_WIDTH-1:0] AW_ADDR,
  input  logic                  W_VALID,
  output logic                  W_READY,
  input  logic [DATA_WIDTH-1:0] W_DATA,
  output logic                  B_VALID,
  input  logic                  B_READY,
  output logic [1:0]            B_RESP,
  input  logic                  AR_VALID,
  output logic                  AR_READY,
  input  logic [ADDR_WIDTH-1:0] AR_ADDR,
  output logic                  R_VALID,
  input  logic                  R_READY,
  output logic [DATA_WIDTH-1:0] R_DATA,
  output logic [1:0]            R_RESP
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WR_CAPTURE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

  // The low two address bits select a byte within the word and are ignored.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1:2] < IDX_W'(NUM_REGS);
  endfunction

  function automatic logic [SEL_W-1:0] addr_sel(input logic [ADDR_WIDTH-1:0] a);
    return a[SEL_W+1:2];
  endfunction

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  wr_state_t             wr_state, wr_state_nxt;
  logic                  aw_done, aw_done_nxt;
  logic                  w_done, w_done_nxt;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_addr_nxt;
  logic [DATA_WIDTH-1:0] wr_data, wr_data_nxt;
  logic                  aw_ready_nxt, w_ready_nxt, b_valid_nxt;
  logic [1:0]            b_resp_nxt;
  logic                  wr_en;

  rd_state_t             rd_state, rd_state_nxt;
  logic                  ar_ready_nxt, r_valid_nxt;
  logic [DATA_WIDTH-1:0] r_data_nxt;
  logic [1:0]            r_resp_nxt;

  // Write path: collect AW and W in any order, commit one edge later, then hold B until accepted.
  always_comb begin
    wr_state_nxt = wr_state;
    aw_done_nxt  = aw_done;
    w_done_nxt   = w_done;
    wr_addr_nxt  = wr_addr;
    wr_data_nxt  = wr_data;
    aw_ready_nxt = AW_READY;
    w_ready_nxt  = W_READY;
    b_valid_nxt  = B_VALID;
    b_resp_nxt   = B_RESP;
    wr_en        = 1'b0;
    case (wr_state)
      WR_CAPTURE: begin
        if (aw_done && w_done) begin
          wr_en        = addr_in_range(wr_addr);
          b_valid_nxt  = 1'b1;
          b_resp_nxt   = addr_in_range(wr_addr) ? RESP_OKAY : RESP_SLVERR;
          wr_state_nxt = WR_RESP;
        end else begin
          if (AW_VALID && AW_READY) begin
            wr_addr_nxt  = AW_ADDR;
            aw_done_nxt  = 1'b1;
            aw_ready_nxt = 1'b0;
          end else if (!aw_done) begin
            aw_ready_nxt = 1'b1;
          end
          if (W_VALID && W_READY) begin
            wr_data_nxt = W_DATA;
            w_done_nxt  = 1'b1;
            w_ready_nxt = 1'b0;
          end else if (!w_done) begin
            w_ready_nxt = 1'b1;
          end
        end
      end
      WR_RESP: begin
        if (B_READY) begin
          b_valid_nxt  = 1'b0;
          aw_ready_nxt = 1'b1;
          w_ready_nxt  = 1'b1;
          aw_done_nxt  = 1'b0;
          w_done_nxt   = 1'b0;
          wr_state_nxt = WR_CAPTURE;
        end
      end
      default: wr_state_nxt = WR_CAPTURE;
    endcase
  end

  // Write-path state and registered write-channel outputs.
  always_ff @(posedge A_CLK or negedge A_RSTn) begin
    if (!A_RSTn) begin
      wr_state <= WR_CAPTURE;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      AW_READY <= 1'b0;
      W_READY  <= 1'b0;
      B_VALID  <= 1'b0;
      B_RESP   <= RESP_OKAY;
    end else begin
      wr_state <= wr_state_nxt;
      aw_done  <= aw_done_nxt;
      w_done   <= w_done_nxt;
      wr_addr  <= wr_addr_nxt;
      wr_data  <= wr_data_nxt;
      AW_READY <= aw_ready_nxt;
      W_READY  <= w_ready_nxt;
      B_VALID  <= b_valid_nxt;
      B_RESP   <= b_resp_nxt;
    end
  end

  // Register bank; a read sampling at the commit edge sees the old value.
  always_ff @(posedge A_CLK or negedge A_RSTn) begin
    if (!A_RSTn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[addr_sel(wr_addr)] <= wr_data;
    end
  end

  // Read path: AR handshake loads R directly, R handshake reopens AR.
  always_comb begin
    rd_state_nxt = rd_state;
    ar_ready_nxt = AR_READY;
    r_valid_nxt  = R_VALID;
    r_data_nxt   = R_DATA;
    r_resp_nxt   = R_RESP;
    case (rd_state)
      RD_IDLE: begin
        if (AR_VALID && AR_READY) begin
          ar_ready_nxt = 1'b0;
          r_valid_nxt  = 1'b1;
          if (addr_in_range(AR_ADDR)) begin
            r_data_nxt = regs[addr_sel(AR_ADDR)];
            r_resp_nxt = RESP_OKAY;
          end else begin
            r_data_nxt = '0;
            r_resp_nxt = RESP_SLVERR;
          end
          rd_state_nxt = RD_RESP;
        end else begin
          ar_ready_nxt = 1'b1;
        end
      end
      RD_RESP: begin
        if (R_READY) begin
          r_valid_nxt  = 1'b0;
          ar_ready_nxt = 1'b1;
          rd_state_nxt = RD_IDLE;
        end
      end
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  // Read-path state and registered read-channel outputs.
  always_ff @(posedge A_CLK or negedge A_RSTn) begin
    if (!A_RSTn) begin
      rd_state <= RD_IDLE;
      AR_READY <= 1'b0;
      R_VALID  <= 1'b0;
      R_DATA   <= '0;
      R_RESP   <= RESP_OKAY;
    end else begin
      rd_state <= rd_state_nxt;
      AR_READY <= ar_ready_nxt;
      R_VALID  <= r_valid_nxt;
      R_DATA   <= r_data_nxt;
      R_RESP   <= r_resp_nxt;
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave.sv
// tb/tb_axi4_lite_slave.sv - self-checking bench for axi4_lite_slave
module tb_axi4_lite_slave;

  logic        A_CLK = 1'b0;
  logic        A_RSTn;
  logic        AW_VALID, AW_READY;
  logic [31:0] AW_ADDR;
  logic        W_VALID, W_READY;
  logic [31:0] W_DATA;
  logic        B_VALID, B_READY;
  logic [1:0]  B_RESP;
  logic        AR_VALID, AR_READY;
  logic [31:0] AR_ADDR;
  logic        R_VALID, R_READY;
  logic [31:0] R_DATA;
  logic [1:0]  R_RESP;

  int checks = 0;
  int errors = 0;

  // Reference register file: word-addressed, four entries.
  logic [31:0] model_mem [4];

  axi4_lite_slave dut (
    .A_CLK(A_CLK), .A_RSTn(A_RSTn),
    .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR),
    .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP)
  );

  always #5 A_CLK = ~A_CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_in_range(input logic [31:0] addr);
    return (addr / 4) < 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    return model_in_range(addr) ? model_mem[addr / 4] : 32'h0;
  endfunction

  function automatic logic [1:0] model_resp(input logic [31:0] addr);
    return model_in_range(addr) ? 2'b00 : 2'b10;
  endfunction

  task automatic tick();
    @(posedge A_CLK);
    #1;
  endtask

  task automatic check_all_outputs_zero(input string tag);
    check({tag, "_aw_ready"}, AW_READY, 0);
    check({tag, "_w_ready"}, W_READY, 0);
    check({tag, "_ar_ready"}, AR_READY, 0);
    check({tag, "_b_valid"}, B_VALID, 0);
    check({tag, "_r_valid"}, R_VALID, 0);
    check({tag, "_b_resp"}, B_RESP, 0);
    check({tag, "_r_resp"}, R_RESP, 0);
    check({tag, "_r_data"}, R_DATA, 0);
  endtask

  // Called just after a rising edge; leaves the bench just after a rising edge.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input int aw_dly, input int w_dly, input int b_dly);
    logic [1:0] exp_resp;
    bit aw_sent, w_sent, aw_hs, w_hs;
    int cyc;
    exp_resp = model_resp(addr);
    aw_sent = 0; w_sent = 0; cyc = 0;
    while (!(aw_sent && w_sent) && cyc < 40) begin
      if (!aw_sent && cyc >= aw_dly) begin AW_VALID = 1; AW_ADDR = addr; end
      if (!w_sent && cyc >= w_dly) begin W_VALID = 1; W_DATA = data; end
      aw_hs = AW_VALID && AW_READY;
      w_hs  = W_VALID && W_READY;
      tick();
      if (aw_hs) begin aw_sent = 1; AW_VALID = 0; check("aw_ready_drop", AW_READY, 0); end
      if (w_hs) begin w_sent = 1; W_VALID = 0; check("w_ready_drop", W_READY, 0); end
      cyc++;
    end
    AW_VALID = 0; W_VALID = 0;
    check("wr_handshakes", {aw_sent, w_sent}, 2'b11);
    check("b_valid_before_commit", B_VALID, 0);
    tick();
    check("b_valid_commit", B_VALID, 1);
    check("b_resp", B_RESP, exp_resp);
    if (model_in_range(addr)) model_mem[addr / 4] = data;
    for (int i = 0; i < b_dly; i++) begin
      tick();
      check("b_valid_hold", B_VALID, 1);
      check("b_resp_hold", B_RESP, exp_resp);
      check("aw_ready_hold", AW_READY, 0);
      check("w_ready_hold", W_READY, 0);
    end
    B_READY = 1;
    tick();
    B_READY = 0;
    check("b_valid_clear", B_VALID, 0);
    check("aw_ready_back", AW_READY, 1);
    check("w_ready_back", W_READY, 1);
  endtask

  task automatic do_read(input logic [31:0] addr, input int r_dly);
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    int cyc;
    exp_data = model_read(addr);
    exp_resp = model_resp(addr);
    AR_ADDR = addr; AR_VALID = 1; cyc = 0;
    while (!AR_READY && cyc < 20) begin tick(); cyc++; end
    check("ar_ready_wait", AR_READY, 1);
    tick();
    AR_VALID = 0;
    check("r_valid_set", R_VALID, 1);
    check("ar_ready_drop", AR_READY, 0);
    check($sformatf("r_data@%h", addr), R_DATA, exp_data);
    check($sformatf("r_resp@%h", addr), R_RESP, exp_resp);
    for (int i = 0; i < r_dly; i++) begin
      tick();
      check("r_valid_hold", R_VALID, 1);
      check("r_data_hold", R_DATA, exp_data);
      check("r_resp_hold", R_RESP, exp_resp);
      check("ar_ready_hold", AR_READY, 0);
    end
    R_READY = 1;
    tick();
    R_READY = 0;
    check("r_valid_clear", R_VALID, 0);
    check("ar_ready_back", AR_READY, 1);
  endtask

  task automatic read_all_regs();
    for (int i = 0; i < 4; i++) do_read(32'(i * 4), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d, old;
    A_RSTn = 0;
    AW_VALID = 0; AW_ADDR = 0; W_VALID = 0; W_DATA = 0; B_READY = 0;
    AR_VALID = 0; AR_ADDR = 0; R_READY = 0;
    for (int i = 0; i < 4; i++) model_mem[i] = 0;

    // Reset held 50 ns, released away from a clock edge.
    #50;
    check_all_outputs_zero("rst");
    #2 A_RSTn = 1;
    #1 check("ready_before_edge", AW_READY, 0);
    tick();
    check("aw_ready_after_rst", AW_READY, 1);
    check("w_ready_after_rst", W_READY, 1);
    check("ar_ready_after_rst", AR_READY, 1);
    read_all_regs();

    // Basic write/read.
    do_write(32'h4, 32'h1234_5678, 0, 0, 0);
    read_all_regs();

    // Channel ordering: W first, AW first, both together.
    do_write(32'h0, 32'hA5A5_0001, 3, 0, 0);
    do_write(32'h8, 32'hA5A5_0002, 0, 2, 0);
    do_write(32'hC, 32'hA5A5_0003, 0, 0, 0);
    read_all_regs();

    // Backpressure on both response channels.
    do_write(32'h8, 32'h0BAD_F00D, 1, 1, 5);
    do_read(32'h8, 5);

    // Out of range.
    do_write(32'h10, 32'hDEAD_BEEF, 0, 0, 0);
    do_read(32'h10, 0);
    read_all_regs();

    // Read sampling at the same edge the write commits returns the old value.
    old = model_read(32'h4);
    AW_ADDR = 32'h4; W_DATA = 32'hCAFE_F00D; AW_VALID = 1; W_VALID = 1;
    check("conc_aw_ready", AW_READY, 1);
    tick();
    AW_VALID = 0; W_VALID = 0;
    AR_ADDR = 32'h4; AR_VALID = 1;
    check("conc_ar_ready", AR_READY, 1);
    tick();
    AR_VALID = 0;
    check("conc_b_valid", B_VALID, 1);
    check("conc_r_valid", R_VALID, 1);
    check("conc_r_data_old", R_DATA, old);
    check("conc_r_resp", R_RESP, 0);
    model_mem[1] = 32'hCAFE_F00D;
    B_READY = 1; R_READY = 1;
    tick();
    B_READY = 0; R_READY = 0;
    check("conc_b_clear", B_VALID, 0);
    check("conc_r_clear", R_VALID, 0);
    do_read(32'h4, 0);

    // Randomized traffic, including ignored byte offsets and wide out-of-range addresses.
    for (int n = 0; n < 16; n++) begin
      case ($urandom_range(0, 5))
        0, 1, 2, 3: a = 32'($urandom_range(0, 3) * 4 + $urandom_range(0, 3));
        4:          a = 32'h10 + 32'($urandom_range(0, 15) * 4);
        default:    a = $urandom | 32'h100;
      endcase
      d = $urandom;
      do_write(a, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      do_read(a, $urandom_range(0, 2));
      do_read(32'($urandom_range(0, 5) * 4 + $urandom_range(0, 3)), $urandom_range(0, 2));
    end
    read_all_regs();

    // Reset asserted while a write response is pending.
    AW_ADDR = 32'h0; W_DATA = 32'h5555_AAAA; AW_VALID = 1; W_VALID = 1;
    tick();
    AW_VALID = 0; W_VALID = 0;
    tick();
    check("pre_rst_b_valid", B_VALID, 1);
    #2 A_RSTn = 0;
    #1 check_all_outputs_zero("mid_rst");
    for (int i = 0; i < 4; i++) model_mem[i] = 0;
    tick();
    tick();
    A_RSTn = 1;
    tick();
    check("aw_ready_after_rst2", AW_READY, 1);
    check("ar_ready_after_rst2", AR_READY, 1);
    read_all_regs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
